clock_enable_chain: RTL and testbench

//  Single-domain successor to the base-band/audio clock divider. An N-stage cascaded divider
//  on clk_s emits one-cycle clock-enable strobes and 50%-style reference clocks per stage.

---
 rtl/clock_enable_pkg.sv | 21 ++
 rtl/div_stage.sv | 48 ++++
 rtl/clock_enable_chain.sv | 97 +++++++++
 tb/tb_clock_enable_chain.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_enable_pkg.sv
// Shared types, reset ratios and ratio clamping for the clock-enable divider chain.
package clock_enable_pkg;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned RATIO_MIN = 2;
  localparam int unsigned M0_DEF    = 250;  // 240 MHz -> 960 kHz
  localparam int unsigned M1_DEF    = 30;   // 960 kHz -> 32 kHz

  typedef logic [W_DEF-1:0] ratio_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } upd_state_t;

  // Ratios below 2 cannot produce a distinct high and low phase, so raise them to 2.
  function automatic logic [31:0] ratio_clamp(input logic [31:0] r);
    return (r < RATIO_MIN) ? 32'(RATIO_MIN) : r;
  endfunction

endpackage

// File: rtl/div_stage.sv
// One divider stage: W-bit counter advancing on adv, registered enable strobe
// and registered reference clock (high for floor(M/2) advances).
module div_stage
  import clock_enable_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk_s,
  input  logic         reset,
  input  logic         adv,
  input  logic         clear,
  input  logic         load_zero,
  input  logic [W-1:0] ratio,
  output logic         wrap,
  output logic         en,
  output logic         clk_out
);

  logic [W-1:0] cnt;
  logic [W-1:0] half_m1;

  assign half_m1 = (ratio >> 1) - W'(1);
  assign wrap    = adv && (cnt == ratio - W'(1));

  // Counter, strobe and reference clock; clear restarts the stage, load_zero only rewinds the counter.
  always_ff @(posedge clk_s or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      en      <= 1'b0;
      clk_out <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      en      <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      en <= wrap;
      if (wrap)
        clk_out <= 1'b1;
      else if (adv && (cnt == half_m1))
        clk_out <= 1'b0;
      if (load_zero || wrap)
        cnt <= '0;
      else if (adv)
        cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/clock_enable_chain.sv
// Cascaded clock-enable divider with runtime ratio update applied at the
// last-stage frame boundary (or immediately on sync).
module clock_enable_chain
  import clock_enable_pkg::*;
#(
  parameter int unsigned N_STAGES = 2,
  parameter int unsigned W        = W_DEF,
  parameter int unsigned M_INIT [N_STAGES] = '{M0_DEF, M1_DEF}
) (
  input  logic                  reset,
  input  logic                  clk_s,
  input  logic                  sync,
  input  logic                  ratio_req,
  input  logic [N_STAGES*W-1:0] ratio_in,
  output logic                  ratio_ack,
  output logic                  busy,
  output logic [N_STAGES-1:0]   en,
  output logic [N_STAGES-1:0]   clk_out,
  output logic                  locked
);

  upd_state_t          state;
  logic [W-1:0]        active [N_STAGES];
  logic [W-1:0]        shadow [N_STAGES];
  logic [N_STAGES-1:0] adv;
  logic [N_STAGES-1:0] wrap;
  logic                apply;

  // A pending update lands on the last-stage wrap, or at once when sync restarts the chain.
  assign apply = (state == PENDING) && (sync || wrap[N_STAGES-1]);

  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign adv[g] = 1'b1;
    end else begin : g_next
      assign adv[g] = en[g-1];
    end

    div_stage #(.W(W)) u_stage (
      .clk_s     (clk_s),
      .reset     (reset),
      .adv       (adv[g]),
      .clear     (sync),
      .load_zero (apply),
      .ratio     (active[g]),
      .wrap      (wrap[g]),
      .en        (en[g]),
      .clk_out   (clk_out[g])
    );
  end

  // Update FSM: latch clamped request into shadow, later copy shadow to active with an ack pulse.
  always_ff @(posedge clk_s or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ratio_ack <= 1'b0;
      for (int unsigned i = 0; i < N_STAGES; i++) begin
        active[i] <= W'(M_INIT[i]);
        shadow[i] <= W'(M_INIT[i]);
      end
    end else begin
      ratio_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (ratio_req) begin
            for (int unsigned i = 0; i < N_STAGES; i++)
              shadow[i] <= W'(ratio_clamp(32'(ratio_in[i*W +: W])));
            state <= PENDING;
            busy  <= 1'b1;
          end
        end
        PENDING: begin
          if (apply) begin
            for (int unsigned i = 0; i < N_STAGES; i++)
              active[i] <= shadow[i];
            ratio_ack <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // locked: first last-stage strobe since the most recent restart or ratio apply.
  always_ff @(posedge clk_s or posedge reset) begin
    if (reset)
      locked <= 1'b0;
    else if (sync || apply)
      locked <= 1'b0;
    else if (wrap[N_STAGES-1])
      locked <= 1'b1;
  end

endmodule

// File: tb/tb_clock_enable_chain.sv
// Directed bench for clock_enable_chain (N_STAGES=2, W=8, M_INIT={250,30}).
module tb_clock_enable_chain;

  logic        reset;
  logic        clk_s;
  logic        sync;
  logic        ratio_req;
  logic [15:0] ratio_in;
  logic        ratio_ack;
  logic        busy;
  logic [1:0]  en;
  logic [1:0]  clk_out;
  logic        locked;

  int vectors    = 0;
  int miscompares = 0;
  int edges      = 0;
  int ack_count  = 0;
  int n;
  int a0;

  clock_enable_chain #(.N_STAGES(2), .W(8)) dut (
    .reset     (reset),
    .clk_s     (clk_s),
    .sync      (sync),
    .ratio_req (ratio_req),
    .ratio_in  (ratio_in),
    .ratio_ack (ratio_ack),
    .busy      (busy),
    .en        (en),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  initial begin
    clk_s = 1'b0;
    forever #5 clk_s = ~clk_s;
  end

  always @(negedge clk_s)
    if (ratio_ack === 1'b1) ack_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return en[0];
      1:       return en[1];
      2:       return clk_out[0];
      default: return ratio_ack;
    endcase
  endfunction

  task automatic step(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      @(posedge clk_s);
      #1;
      edges++;
    end
  endtask

  // Edges until sig(sel)==val, -1 if the budget expires.
  task automatic wait_sig(input int sel, input logic val, input int budget, output int res);
    res = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk_s);
      #1;
      edges++;
      if (sig(sel) === val) begin
        res = k;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; sync = 1'b0; ratio_req = 1'b0; ratio_in = '0;
    repeat (3) @(negedge clk_s);
    check("rst_en", 32'(en), 0);
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_ack", 32'(ratio_ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_locked", 32'(locked), 0);

    // 1. Default ratios
    reset = 1'b0; edges = 0;
    wait_sig(0, 1'b1, 400, n);  check("en0_first", n, 250);
    check("clk0_rise_with_en0", 32'(clk_out[0]), 1);
    wait_sig(2, 1'b0, 400, n);  check("clk0_high", n, 125);
    wait_sig(2, 1'b1, 400, n);  check("clk0_low", n, 125);
    check("en0_with_clk0", 32'(en[0]), 1);
    check("locked_early", 32'(locked), 0);
    wait_sig(1, 1'b1, 8000, n); check("en1_first_edge", edges, 7501);
    check("locked_set", 32'(locked), 1);
    wait_sig(1, 1'b1, 8000, n); check("en1_period", n, 7500);

    // 2. Update to {100,10} mid-frame
    step(1000);
    ratio_in = {8'd10, 8'd100}; ratio_req = 1'b1;
    step(1);
    ratio_req = 1'b0;
    check("busy_after_req", 32'(busy), 1);
    check("no_early_ack", 32'(ratio_ack), 0);
    wait_sig(3, 1'b1, 8000, n); check("ack_at_frame", n, 6499);
    check("en1_at_ack", 32'(en[1]), 1);
    check("busy_cleared", 32'(busy), 0);
    check("locked_cleared_apply", 32'(locked), 0);
    step(1);
    check("ack_one_cycle", 32'(ratio_ack), 0);
    wait_sig(0, 1'b1, 400, n);  check("en0_after_apply", n, 99);
    wait_sig(0, 1'b1, 400, n);  check("en0_period_100", n, 100);
    wait_sig(1, 1'b1, 2000, n); check("en1_after_apply", n, 801);
    check("locked_relock", 32'(locked), 1);
    wait_sig(1, 1'b1, 2000, n); check("en1_period_1000", n, 1000);

    // 3. Odd ratio {5,3}
    ratio_in = {8'd3, 8'd5}; ratio_req = 1'b1;
    step(1);
    ratio_req = 1'b0;
    wait_sig(3, 1'b1, 2000, n); check("ack_53", n, 999);
    wait_sig(0, 1'b1, 50, n);   check("en0_first_5", n, 5);
    wait_sig(2, 1'b0, 50, n);   check("clk0_high_odd", n, 2);
    wait_sig(2, 1'b1, 50, n);   check("clk0_low_odd", n, 3);
    wait_sig(1, 1'b1, 50, n);   check("en1_first_15", n, 6);
    wait_sig(1, 1'b1, 50, n);   check("en1_period_15", n, 15);

    // Clamp: {0,1} loads as {2,2}
    ratio_in = {8'd1, 8'd0}; ratio_req = 1'b1;
    step(1);
    ratio_req = 1'b0;
    wait_sig(3, 1'b1, 50, n);   check("ack_clamp", n, 14);
    wait_sig(1, 1'b1, 50, n);   check("en1_first_clamp", n, 5);
    wait_sig(1, 1'b1, 50, n);   check("en1_period_4", n, 4);
    wait_sig(0, 1'b1, 50, n);   check("en0_next_clamp", n, 1);
    wait_sig(0, 1'b1, 50, n);   check("en0_period_2", n, 2);
    wait_sig(2, 1'b0, 50, n);   check("clk0_high_2", n, 1);
    wait_sig(2, 1'b1, 50, n);   check("clk0_low_2", n, 1);

    // 4. sync while PENDING with {6,4}
    ratio_in = {8'd4, 8'd6}; ratio_req = 1'b1;
    step(1);
    ratio_req = 1'b0;
    check("busy_before_sync", 32'(busy), 1);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    check("sync_ack", 32'(ratio_ack), 1);
    check("sync_en", 32'(en), 0);
    check("sync_clk_out", 32'(clk_out), 0);
    check("sync_locked", 32'(locked), 0);
    check("sync_busy", 32'(busy), 0);
    wait_sig(0, 1'b1, 50, n);   check("en0_after_sync", n, 6);
    wait_sig(1, 1'b1, 100, n);  check("en1_after_sync", n, 19);
    check("locked_after_sync", 32'(locked), 1);

    // 5. Second request while busy is ignored
    a0 = ack_count;
    ratio_in = {8'd3, 8'd4}; ratio_req = 1'b1;
    step(1);
    ratio_in = {8'd10, 8'd100};
    step(1);
    ratio_req = 1'b0;
    check("busy_second_req", 32'(busy), 1);
    wait_sig(3, 1'b1, 100, n);  check("ack_first_req", n, 22);
    step(300);
    check("single_ack", ack_count - a0, 1);
    wait_sig(0, 1'b1, 50, n);
    wait_sig(0, 1'b1, 50, n);   check("en0_period_4", n, 4);
    wait_sig(1, 1'b1, 50, n);
    wait_sig(1, 1'b1, 50, n);   check("en1_period_12", n, 12);

    // 6. Async reset mid-frame and mid-PENDING
    wait_sig(0, 1'b1, 50, n);
    ratio_in = {8'd3, 8'd5}; ratio_req = 1'b1;
    step(1);
    ratio_req = 1'b0;
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_clk0", 32'(clk_out[0]), 1);
    check("pre_rst_locked", 32'(locked), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_en", 32'(en), 0);
    check("arst_clk_out", 32'(clk_out), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_ack", 32'(ratio_ack), 0);
    repeat (2) @(negedge clk_s);
    a0 = ack_count;
    reset = 1'b0; edges = 0;
    wait_sig(0, 1'b1, 400, n);  check("en0_first_rerst", n, 250);
    wait_sig(1, 1'b1, 8000, n); check("en1_first_rerst", edges, 7501);
    check("no_ack_after_rst", ack_count - a0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
